// File: rtl/axi_w_route_mux_pkg.sv
// axi_w_route_mux_pkg: shared interconnect constants and the AW route entry type
package axi_w_route_mux_pkg;
    localparam int DEF_NUM_SLV = 4;
    localparam int DEF_SEL_W   = 4;
    localparam int DEF_LEN_W   = 8;
    localparam int DEF_DEPTH   = 4;

    typedef struct packed {
        logic [DEF_SEL_W-1:0] sel;
        logic [DEF_LEN_W-1:0] len;
    } route_t;
endpackage

// File: rtl/axi_route_fifo.sv
// axi_route_fifo: in-order route queue, push ignored when full, pop ignored when empty
module axi_route_fifo
    import axi_w_route_mux_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int W     = $bits(route_t)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic          do_push, do_pop;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign cnt_o   = cnt_q;
    assign dout_o  = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next-state: pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q + AW'(do_push);
        rptr_d = rptr_q + AW'(do_pop);
        cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
        if (do_push) mem_d[wptr_q] = din_i;
    end

    // State registers; reset empties the queue
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/axi_w_route_mux.sv
// axi_w_route_mux: steers W beats to the slave chosen by the queued AW route
module axi_w_route_mux
    import axi_w_route_mux_pkg::*;
#(
    parameter int NUM_SLV = DEF_NUM_SLV,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       aw_push_i,
    input  logic [SEL_W-1:0]           aw_sel_i,
    input  logic [LEN_W-1:0]           aw_len_i,
    output logic                       aw_ready_o,
    input  logic                       wvalid_i,
    input  logic                       wlast_i,
    output logic                       wready_o,
    output logic [NUM_SLV-1:0]         s_wvalid_o,
    input  logic [NUM_SLV-1:0]         s_wready_i,
    output logic [$clog2(DEPTH+1)-1:0] pend_cnt_o,
    output logic                       dec_err_o,
    output logic                       len_err_o,
    input  logic                       err_clr_i
);
    logic [SEL_W+LEN_W-1:0] head;
    logic [SEL_W-1:0]       sel;
    logic [LEN_W-1:0]       len;
    logic [NUM_SLV-1:0]     hit;
    logic [LEN_W:0]         cnt_q, cnt_d;
    logic                   dec_err_q, dec_err_d, len_err_q, len_err_d;
    logic                   empty, full, vld, mapped, acc, pop, len_bad;

    axi_route_fifo #(.DEPTH(DEPTH), .W(SEL_W+LEN_W)) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (aw_push_i),
        .pop_i  (pop),
        .din_i  ({aw_sel_i, aw_len_i}),
        .dout_o (head),
        .full_o (full),
        .empty_o(empty),
        .cnt_o  (pend_cnt_o)
    );

    assign {sel, len}  = head;
    assign vld         = !empty;
    assign mapped      = int'(sel) < NUM_SLV;
    assign aw_ready_o  = !full;
    assign s_wvalid_o  = hit & {NUM_SLV{wvalid_i}};
    assign wready_o    = vld && (mapped ? |(hit & s_wready_i) : 1'b1);
    assign acc         = wvalid_i && wready_o;
    assign pop         = acc && wlast_i;
    assign len_bad     = acc && (wlast_i ? cnt_q != {1'b0, len} : cnt_q == {1'b0, len});
    assign dec_err_o   = dec_err_q;
    assign len_err_o   = len_err_q;

    // One-hot decode of the head select; unmapped selects hit nothing
    always_comb begin
        for (int i = 0; i < NUM_SLV; i++) hit[i] = vld && (int'(sel) == i);
    end

    // Beat position and sticky errors; a same-cycle set beats the clear
    always_comb begin
        cnt_d     = pop ? '0 : cnt_q + (LEN_W+1)'(acc);
        dec_err_d = (acc && !mapped) || (dec_err_q && !err_clr_i);
        len_err_d = len_bad || (len_err_q && !err_clr_i);
    end

    // Beat counter and error flag registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            dec_err_q <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dec_err_q <= dec_err_d;
            len_err_q <= len_err_d;
        end
    end
endmodule

// File: tb/tb_axi_w_route_mux.sv
// tb_axi_w_route_mux: vector table, directed corner cases and random traffic against a queue model
module tb_axi_w_route_mux;
    import axi_w_route_mux_pkg::*;

    localparam int NS    = 4;
    localparam int DEPTH = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       aw_push_i = 1'b0;
    logic [3:0] aw_sel_i = '0;
    logic [7:0] aw_len_i = '0;
    logic       aw_ready_o;
    logic       wvalid_i = 1'b0;
    logic       wlast_i = 1'b0;
    logic       wready_o;
    logic [3:0] s_wvalid_o;
    logic [3:0] s_wready_i = '0;
    logic [2:0] pend_cnt_o;
    logic       dec_err_o, len_err_o;
    logic       err_clr_i = 1'b0;

    int     checks = 0;
    int     errors = 0;
    route_t rq[$];
    int     mcnt = 0;
    bit     mdec = 1'b0;
    bit     mlen = 1'b0;

    typedef struct {
        int push, sel, len, wv, wl, srdy, eswv, ewr, epend, eawr;
    } vec_t;
    vec_t vt[11];

    always #5 clk_i = ~clk_i;

    axi_w_route_mux dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .aw_push_i (aw_push_i),
        .aw_sel_i  (aw_sel_i),
        .aw_len_i  (aw_len_i),
        .aw_ready_o(aw_ready_o),
        .wvalid_i  (wvalid_i),
        .wlast_i   (wlast_i),
        .wready_o  (wready_o),
        .s_wvalid_o(s_wvalid_o),
        .s_wready_i(s_wready_i),
        .pend_cnt_o(pend_cnt_o),
        .dec_err_o (dec_err_o),
        .len_err_o (len_err_o),
        .err_clr_i (err_clr_i)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic drive(input int push, input int sel, input int len, input int wv,
                         input int wl, input int srdy, input int clr);
        aw_push_i  = 1'(push);
        aw_sel_i   = 4'(sel);
        aw_len_i   = 8'(len);
        wvalid_i   = 1'(wv);
        wlast_i    = 1'(wl);
        s_wready_i = 4'(srdy);
        err_clr_i  = 1'(clr);
        @(negedge clk_i);
    endtask

    // Checks outputs against the queue model, then advances the model across the next edge
    task automatic model_step();
        route_t     h;
        int         sz;
        logic [3:0] eswv;
        bit         ewr, acc, full, dset, lset;
        sz   = rq.size();
        h    = '0;
        eswv = '0;
        ewr  = 1'b0;
        if (sz > 0) begin
            h = rq[0];
            if (int'(h.sel) < NS) begin
                eswv = wvalid_i ? 4'(1 << h.sel) : 4'b0;
                ewr  = s_wready_i[h.sel[1:0]];
            end else begin
                ewr = 1'b1;
            end
        end
        chk("m_swvalid", 32'(s_wvalid_o), 32'(eswv));
        chk("m_wready", 32'(wready_o), 32'(ewr));
        chk("m_pend", 32'(pend_cnt_o), 32'(sz));
        chk("m_awready", 32'(aw_ready_o), 32'(sz < DEPTH));
        chk("m_dec_err", 32'(dec_err_o), 32'(mdec));
        chk("m_len_err", 32'(len_err_o), 32'(mlen));
        acc  = wvalid_i && ewr;
        full = sz == DEPTH;
        dset = 1'b0;
        lset = 1'b0;
        if (acc) begin
            dset = int'(h.sel) >= NS;
            lset = wlast_i ? (mcnt != int'(h.len)) : (mcnt == int'(h.len));
            if (wlast_i) begin
                void'(rq.pop_front());
                mcnt = 0;
            end else begin
                mcnt++;
            end
        end
        mdec = dset || (mdec && !err_clr_i);
        mlen = lset || (mlen && !err_clr_i);
        if (aw_push_i && !full) rq.push_back(route_t'{sel: aw_sel_i, len: aw_len_i});
        @(posedge clk_i);
        #1;
    endtask

    task automatic cyc(input int push, input int sel, input int len, input int wv,
                       input int wl, input int srdy, input int clr);
        drive(push, sel, len, wv, wl, srdy, clr);
        model_step();
    endtask

    initial begin
        vt[0]  = '{1, 2, 3, 0, 0, 4'b0100, 4'b0000, 0, 0, 1};
        vt[1]  = '{0, 0, 0, 1, 0, 4'b0100, 4'b0100, 1, 1, 1};
        vt[2]  = '{0, 0, 0, 1, 0, 4'b0100, 4'b0100, 1, 1, 1};
        vt[3]  = '{0, 0, 0, 1, 0, 4'b0100, 4'b0100, 1, 1, 1};
        vt[4]  = '{0, 0, 0, 1, 1, 4'b0100, 4'b0100, 1, 1, 1};
        vt[5]  = '{0, 0, 0, 0, 0, 4'b0100, 4'b0000, 0, 0, 1};
        vt[6]  = '{1, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0, 1};
        vt[7]  = '{1, 3, 1, 1, 1, 4'b1111, 4'b0001, 1, 1, 1};
        vt[8]  = '{0, 0, 0, 1, 0, 4'b1111, 4'b1000, 1, 1, 1};
        vt[9]  = '{0, 0, 0, 1, 1, 4'b1111, 4'b1000, 1, 1, 1};
        vt[10] = '{0, 0, 0, 0, 0, 4'b1111, 4'b0000, 0, 0, 1};

        wvalid_i   = 1'b1;
        s_wready_i = 4'b1111;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_awready", 32'(aw_ready_o), 32'd1);
        chk("rst_wready", 32'(wready_o), 32'd0);
        chk("rst_swvalid", 32'(s_wvalid_o), 32'd0);
        chk("rst_pend", 32'(pend_cnt_o), 32'd0);
        chk("rst_dec_err", 32'(dec_err_o), 32'd0);
        chk("rst_len_err", 32'(len_err_o), 32'd0);
        @(negedge clk_i);
        rst_ni   = 1'b1;
        wvalid_i = 1'b0;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 11; i++) begin
            drive(vt[i].push, vt[i].sel, vt[i].len, vt[i].wv, vt[i].wl, vt[i].srdy, 0);
            chk($sformatf("vec%0d_swvalid", i), 32'(s_wvalid_o), 32'(vt[i].eswv));
            chk($sformatf("vec%0d_wready", i), 32'(wready_o), 32'(vt[i].ewr));
            chk($sformatf("vec%0d_pend", i), 32'(pend_cnt_o), 32'(vt[i].epend));
            chk($sformatf("vec%0d_awready", i), 32'(aw_ready_o), 32'(vt[i].eawr));
            model_step();
        end

        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0, 0, 4'b1111, 0);
        chk("full_awready", 32'(aw_ready_o), 32'd0);
        chk("full_pend", 32'(pend_cnt_o), 32'd4);
        cyc(0, 0, 0, 1, 1, 4'b1111, 0);
        chk("pop_awready", 32'(aw_ready_o), 32'd1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1, 4'b1111, 0);
        chk("fifth_push_dropped", 32'(pend_cnt_o), 32'd0);

        cyc(1, 9, 1, 0, 0, 4'b0000, 0);
        cyc(0, 0, 0, 1, 0, 4'b0000, 0);
        cyc(0, 0, 0, 1, 1, 4'b0000, 0);
        chk("dec_set", 32'(dec_err_o), 32'd1);
        chk("dec_no_len_err", 32'(len_err_o), 32'd0);
        chk("dec_sunk", 32'(pend_cnt_o), 32'd0);
        cyc(0, 0, 0, 0, 0, 4'b0000, 1);
        chk("dec_clr", 32'(dec_err_o), 32'd0);

        cyc(1, 1, 3, 0, 0, 4'b1111, 0);
        cyc(1, 2, 0, 1, 0, 4'b1111, 0);
        cyc(0, 0, 0, 1, 1, 4'b1111, 0);
        chk("len_set", 32'(len_err_o), 32'd1);
        chk("len_popped", 32'(pend_cnt_o), 32'd1);
        cyc(0, 0, 0, 1, 1, 4'b1111, 0);
        chk("len_next_done", 32'(pend_cnt_o), 32'd0);
        cyc(0, 0, 0, 0, 0, 4'b1111, 1);
        chk("len_clr", 32'(len_err_o), 32'd0);

        cyc(1, 0, 1, 0, 0, 4'b1111, 0);
        cyc(1, 3, 2, 1, 0, 4'b1111, 0);
        wvalid_i  = 1'b1;
        aw_push_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_swvalid", 32'(s_wvalid_o), 32'd0);
        chk("midrst_pend", 32'(pend_cnt_o), 32'd0);
        chk("midrst_wready", 32'(wready_o), 32'd0);
        rq.delete();
        mcnt = 0;
        mdec = 1'b0;
        mlen = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        chk("midrst_awready", 32'(aw_ready_o), 32'd1);
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 400; i++)
            cyc(int'($urandom_range(0, 1)), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 2) == 0),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 19) == 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
